// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA raster constants and the sprite FSM state type.
//   H_ACTIVE/V_ACTIVE  visible raster size; anything at or beyond is clipped
//   CNT_W              width of the hcount/vcount raster counters
//   DATA_W             pixel width (RRGGBB)
//   sprite_state_t     per-sprite raster walker states
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int CNT_W    = 10;
    localparam int DATA_W   = 6;
    typedef enum logic [1:0] {IDLE, LINE_WAIT, RUN, DONE} sprite_state_t;
endpackage

// File: rtl/sprite_anim_ctr.sv
// sprite_anim_ctr: divides frame_tick by ANIM_DIV and steps the animation frame.
//   clk, reset      pixel clock, synchronous active-high reset
//   frame_tick_i    1-clk pulse per video frame
//   anim_en_i       1 = count frame ticks, 0 = hold the current frame
//   frame_idx_o     current animation frame, wraps FRAMES-1 -> 0
//   frame_base_o    ROM offset of the current frame (frame_idx * FRM_SZ), kept
//                   as a running sum so no multiplier is needed
module sprite_anim_ctr #(
    parameter int FRAMES   = 3,
    parameter int ANIM_DIV = 8,
    parameter int FRM_SZ   = 1840,
    parameter int FI_W     = 2,
    parameter int ADDR_W   = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick_i,
    input  logic              anim_en_i,
    output logic [FI_W-1:0]   frame_idx_o,
    output logic [ADDR_W-1:0] frame_base_o
);
    localparam int DIV_W = $clog2(ANIM_DIV + 1);
    logic [DIV_W-1:0]  div_q;
    logic [FI_W-1:0]   idx_q;
    logic [ADDR_W-1:0] base_q;
    logic              count, step, wrap;
    assign count = frame_tick_i && anim_en_i;
    assign step  = count && div_q == DIV_W'(ANIM_DIV - 1);
    assign wrap  = idx_q == FI_W'(FRAMES - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            idx_q  <= '0;
            base_q <= '0;
        end else begin
            if (count)
                div_q <= step ? '0 : div_q + DIV_W'(1);
            if (step) begin
                idx_q  <= wrap ? '0 : idx_q + FI_W'(1);
                base_q <= wrap ? '0 : base_q + ADDR_W'(FRM_SZ);
            end
        end
    end
    assign frame_idx_o  = idx_q;
    assign frame_base_o = base_q;
endmodule

// File: rtl/sprite_drawer.sv
// sprite_drawer: animated sprite renderer; walks a multi-frame sprite ROM against
// the raster and emits a registered pixel plus draw qualifier.
//   clk, reset            pixel clock, synchronous active-high reset
//   hcount, vcount        raster position
//   frame_tick            start of vertical blanking; latches x/y/enable/flip
//   x_pos, y_pos          sprite origin (used from the next frame_tick)
//   enable, flip_h        per-frame draw enable and horizontal mirror
//   anim_en               advance animation frames
//   rom_addr / rom_data   synchronous sprite ROM, 1-clk read latency
//   pixel, draw           output pixel and its qualifier, 2 clks behind hcount
//   frame_idx             current animation frame
module sprite_drawer #(
    parameter int SPR_W    = 46,
    parameter int SPR_H    = 40,
    parameter int FRAMES   = 3,
    parameter int DATA_W   = vga_pkg::DATA_W,
    parameter logic [DATA_W-1:0] TRANSP = '0,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int ANIM_DIV = 8,
    localparam int ADDR_W  = $clog2(SPR_W * SPR_H * FRAMES),
    localparam int FI_W    = FRAMES > 1 ? $clog2(FRAMES) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [vga_pkg::CNT_W-1:0] hcount,
    input  logic [vga_pkg::CNT_W-1:0] vcount,
    input  logic                      frame_tick,
    input  logic [vga_pkg::CNT_W-1:0] x_pos,
    input  logic [vga_pkg::CNT_W-1:0] y_pos,
    input  logic                      enable,
    input  logic                      flip_h,
    input  logic                      anim_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [DATA_W-1:0]         pixel,
    output logic                      draw,
    output logic [FI_W-1:0]           frame_idx
);
    import vga_pkg::*;
    localparam int COL_W = $clog2(SPR_W + 1);
    localparam int ROW_W = $clog2(SPR_H + 1);
    sprite_state_t     state_q;
    logic [CNT_W-1:0]  x_lat_q, y_lat_q;
    logic              en_lat_q, flip_lat_q;
    logic [COL_W-1:0]  col_q, col_eff;
    logic [ROW_W-1:0]  row_q;
    logic [ADDR_W-1:0] base_q, frame_base, rom_addr_q, addr_d;
    logic              run1_q, run2_q, vis1_q, vis2_q, draw_q;
    logic [DATA_W-1:0] pixel_q;
    logic              emit, last_col, last_row, opaque;
    sprite_anim_ctr #(
        .FRAMES  (FRAMES),
        .ANIM_DIV(ANIM_DIV),
        .FRM_SZ  (SPR_W * SPR_H),
        .FI_W    (FI_W),
        .ADDR_W  (ADDR_W)
    ) u_anim (
        .clk         (clk),
        .reset       (reset),
        .frame_tick_i(frame_tick),
        .anim_en_i   (anim_en),
        .frame_idx_o (frame_idx),
        .frame_base_o(frame_base)
    );
    // The first column is emitted from LINE_WAIT on the edge where hcount reaches
    // the origin, so rom_addr for column h is registered at the hcount==h edge.
    assign emit     = !frame_tick && ((state_q == LINE_WAIT && hcount == x_lat_q) || state_q == RUN);
    assign col_eff  = state_q == RUN ? col_q : '0;
    assign last_col = col_eff == COL_W'(SPR_W - 1);
    assign last_row = row_q == ROW_W'(SPR_H - 1);
    assign addr_d   = base_q + ADDR_W'(flip_lat_q ? COL_W'(SPR_W - 1) - col_eff : col_eff);
    // run/vis flags travel two stages so they line up with rom_data.
    assign opaque   = run2_q && vis2_q && rom_data != TRANSP;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            x_lat_q    <= '0;
            y_lat_q    <= '0;
            en_lat_q   <= 1'b0;
            flip_lat_q <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            base_q     <= '0;
            rom_addr_q <= '0;
            run1_q     <= 1'b0;
            run2_q     <= 1'b0;
            vis1_q     <= 1'b0;
            vis2_q     <= 1'b0;
            draw_q     <= 1'b0;
            pixel_q    <= '0;
        end else begin
            run1_q <= emit;
            vis1_q <= hcount < CNT_W'(H_ACTIVE) && vcount < CNT_W'(V_ACTIVE);
            run2_q <= run1_q;
            vis2_q <= vis1_q;
            draw_q <= opaque;
            if (opaque)
                pixel_q <= rom_data;
            if (emit)
                rom_addr_q <= addr_d;
            if (frame_tick) begin
                x_lat_q    <= x_pos;
                y_lat_q    <= y_pos;
                en_lat_q   <= enable;
                flip_lat_q <= flip_h;
                state_q    <= IDLE;
                row_q      <= '0;
                col_q      <= '0;
            end else if (state_q == IDLE) begin
                // Base is rebuilt here so a new animation frame never tears mid-sprite.
                if (vcount == y_lat_q && en_lat_q) begin
                    state_q <= LINE_WAIT;
                    base_q  <= frame_base;
                    row_q   <= '0;
                    col_q   <= '0;
                end
            end else if (emit) begin
                if (last_col) begin
                    col_q   <= '0;
                    state_q <= last_row ? DONE : LINE_WAIT;
                    row_q   <= row_q + ROW_W'(1);
                    base_q  <= base_q + ADDR_W'(SPR_W);
                end else begin
                    col_q   <= col_eff + COL_W'(1);
                    state_q <= RUN;
                end
            end
        end
    end
    assign rom_addr = rom_addr_q;
    assign pixel    = pixel_q;
    assign draw     = draw_q;
endmodule

// File: tb/tb_sprite_drawer.sv
// tb_sprite_drawer: directed raster walks against a geometric sprite model with a
// scoreboard aligned to the 2-clk pixel latency.
module tb_sprite_drawer;
    localparam int SW = 46;
    localparam int SH = 40;
    localparam int FS = SW * SH;
    localparam int NA = FS * 3;
    logic        clk = 1'b0, reset = 1'b1, frame_tick = 1'b0;
    logic        enable = 1'b0, flip_h = 1'b0, anim_en = 1'b0;
    logic [9:0]  hcount = '0, vcount = '0, x_pos = '0, y_pos = '0;
    logic [12:0] rom_addr;
    logic [5:0]  rom_data, pixel;
    logic        draw;
    logic [1:0]  frame_idx;
    logic [5:0]  rom [NA];
    int n_chk = 0, n_err = 0;
    int m_x = 0, m_y = 0, m_div = 0, m_idx = 0;
    bit m_en = 0, m_flip = 0, m_hold = 0;
    typedef struct {bit d; logic [5:0] p; int h; int v;} exp_t;
    exp_t sb[$];

    sprite_drawer dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .frame_tick(frame_tick), .x_pos(x_pos), .y_pos(y_pos), .enable(enable),
        .flip_h(flip_h), .anim_en(anim_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .pixel(pixel), .draw(draw), .frame_idx(frame_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= (rom_addr < 13'(NA)) ? rom[rom_addr] : '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic step(input int h, input int v, input bit tk, input bit rs);
        bit in_s;
        int a;
        exp_t e;
        hcount = 10'(h); vcount = 10'(v); frame_tick = tk; reset = rs;
        in_s = !tk && !rs && m_en && v >= m_y && v < m_y + SH && h >= m_x && h < m_x + SW;
        a = in_s ? m_idx * FS + (v - m_y) * SW + (m_flip ? SW - 1 - (h - m_x) : h - m_x) : 0;
        e.d = in_s && h < 640 && v < 480 && rom[a] != 6'h00;
        e.p = rom[a]; e.h = h; e.v = v;
        @(posedge clk);
        if (rs) begin
            m_en = 0; m_flip = 0; m_x = 0; m_y = 0; m_div = 0; m_idx = 0; m_hold = 1;
            sb.delete();
        end
        if (tk) begin
            m_x = int'(x_pos); m_y = int'(y_pos); m_en = enable; m_flip = flip_h; m_hold = 0;
            if (anim_en) begin
                if (m_div == 7) begin m_div = 0; m_idx = (m_idx + 1) % 3; end
                else m_div++;
            end
        end
        #1;
        if (tk) chk("frame_idx", 32'(frame_idx), 32'(m_idx));
        if (in_s) chk($sformatf("rom_addr h%0d v%0d", h, v), 32'(rom_addr), 32'(a));
        if (m_hold) begin
            chk($sformatf("hold rom_addr h%0d v%0d", h, v), 32'(rom_addr), 0);
            chk($sformatf("hold draw h%0d v%0d", h, v), 32'(draw), 0);
        end
        if (!rs) begin
            sb.push_back(e);
            if (sb.size() == 3) begin
                e = sb.pop_front();
                chk($sformatf("draw h%0d v%0d", e.h, e.v), 32'(draw), 32'(e.d));
                if (e.d) chk($sformatf("pixel h%0d v%0d", e.h, e.v), 32'(pixel), 32'(e.p));
            end
        end
    endtask

    task automatic line(input int v, input int x);
        for (int h = x - 3; h <= x + SW + 3; h++) step(h, v, 0, 0);
    endtask

    task automatic do_tick();
        step(0, 480, 1, 0);
    endtask

    initial begin
        for (int a = 0; a < NA; a++) rom[a] = 6'((a % 63) + 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("reset pixel", 32'(pixel), 0);
        chk("reset frame_idx", 32'(frame_idx), 0);
        // 1: plain sprite, full frame incl. line past the bottom
        x_pos = 10'd100; y_pos = 10'd50; enable = 1'b1;
        do_tick();
        for (int v = 50; v <= 90; v++) line(v, 100);
        // 2: mirrored
        flip_h = 1'b1;
        do_tick();
        for (int v = 50; v <= 52; v++) line(v, 100);
        // 3: transparent pixel at address 5
        flip_h = 1'b0;
        rom[5] = 6'h00;
        do_tick();
        for (int v = 50; v <= 51; v++) line(v, 100);
        rom[5] = 6'(5 % 63 + 1);
        // 4: right-edge clipping
        x_pos = 10'd620;
        do_tick();
        for (int v = 50; v <= 52; v++) line(v, 620);
        // 5: animation
        x_pos = 10'd100; anim_en = 1'b1;
        for (int i = 0; i < 8; i++) do_tick();
        for (int v = 50; v <= 51; v++) line(v, 100);
        for (int i = 0; i < 16; i++) do_tick();
        anim_en = 1'b0;
        // 6: mid-frame position change then reset mid-line
        do_tick();
        for (int v = 50; v <= 59; v++) begin
            if (v == 55) x_pos = 10'd200;
            line(v, 100);
        end
        for (int h = 97; h < 120; h++) step(h, 60, 0, 0);
        step(120, 60, 0, 1);
        for (int h = 121; h <= 149; h++) step(h, 60, 0, 0);
        for (int v = 61; v <= 70; v++) line(v, 100);
        do_tick();
        for (int v = 50; v <= 52; v++) line(v, 200);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
